// File: rtl/pdm_pcm_decimator_if.sv
// Word-input and PCM-output handshake bundle between the PDM deserializer, the decimator
// and the PCM sample consumer.
interface pdm_pcm_decimator_if #(
  parameter int PCM_WIDTH = 16
);
  logic                 word_valid_i;
  logic [15:0]          word_i;
  logic                 pcm_valid_o;
  logic                 pcm_ready_i;
  logic [PCM_WIDTH-1:0] pcm_o;
  logic                 overrun_o;

  modport master (
    output word_valid_i, word_i, pcm_ready_i,
    input  pcm_valid_o, pcm_o, overrun_o
  );

  modport slave (
    input  word_valid_i, word_i, pcm_ready_i,
    output pcm_valid_o, pcm_o, overrun_o
  );
endinterface

// File: rtl/pdm_pcm_decimator.sv
// PDM-to-PCM decimator: popcount per word, boxcar moving sum, decimation, signed scaling.
// Optional PDM_DECIM_OVERRUN_CNT_EN adds a saturating dropped-sample counter port.
module pdm_pcm_decimator #(
  parameter int AVG_LOG2  = 2,
  parameter int DECIM     = 4,
  parameter int PCM_WIDTH = 16
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  pdm_pcm_decimator_if.slave bus
`ifdef PDM_DECIM_OVERRUN_CNT_EN
  ,output logic [15:0]       overrun_cnt_o
`endif
);
  localparam int N     = 1 << AVG_LOG2;
  localparam int SW    = AVG_LOG2 + 5;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int WW    = PCM_WIDTH + 1;
  localparam int SHIFT = PCM_WIDTH - 4 - AVG_LOG2;

  logic [4:0]           r_ones;
  logic                 r_onesValid;
  logic [SW-1:0]        r_sum;
  logic [4:0]           r_slot [N];
  logic [AVG_LOG2-1:0]  r_wptr;
  logic [FW-1:0]        r_fill;
  logic [DCW-1:0]       r_dcnt;
  logic                 r_due;
  logic                 r_pcmValid;
  logic [PCM_WIDTH-1:0] r_pcm;
  logic                 r_overrun;
  logic [4:0]           w_ones;
  logic [SW-1:0]        w_diff;
  logic signed [WW-1:0] w_wide;
  logic [PCM_WIDTH-1:0] w_pcm;

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < 16; i++) begin
      w_ones = w_ones + 5'(bus.word_i[i]);
    end
  end

  // Only +full-scale can overflow after the shift; it shows up as a sign/MSB disagreement.
  assign w_diff = r_sum - SW'(8 * N);
  assign w_wide = WW'($signed(w_diff)) <<< SHIFT;
  assign w_pcm  = (w_wide[WW-1] != w_wide[WW-2]) ? {1'b0, {(PCM_WIDTH-1){1'b1}}}
                                                 : w_wide[PCM_WIDTH-1:0];

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_ones      <= '0;
      r_onesValid <= 1'b0;
      r_sum       <= '0;
      r_wptr      <= '0;
      r_fill      <= '0;
      r_dcnt      <= '0;
      r_due       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_ones      <= w_ones;
      r_onesValid <= bus.word_valid_i;
      r_due       <= 1'b0;
      if (r_onesValid) begin
        r_sum          <= r_sum + SW'(r_ones) - SW'(r_slot[r_wptr]);
        r_slot[r_wptr] <= r_ones;
        r_wptr         <= r_wptr + 1'b1;
        // First full window emits immediately, then every DECIM words.
        if (r_fill != FW'(N)) begin
          r_fill <= r_fill + 1'b1;
          if (r_fill == FW'(N - 1)) begin
            r_due  <= 1'b1;
            r_dcnt <= '0;
          end
        end else if (r_dcnt == DCW'(DECIM - 1)) begin
          r_due  <= 1'b1;
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_pcmValid <= 1'b0;
      r_pcm      <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_due && (!r_pcmValid || bus.pcm_ready_i)) begin
        r_pcmValid <= 1'b1;
        r_pcm      <= w_pcm;
      end else if (r_due) begin
        r_overrun <= 1'b1;
      end else if (r_pcmValid && bus.pcm_ready_i) begin
        r_pcmValid <= 1'b0;
      end
    end
  end

`ifdef PDM_DECIM_OVERRUN_CNT_EN
  logic [15:0] r_overrunCnt;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_overrunCnt <= '0;
    end else if (r_overrun && (r_overrunCnt != 16'hFFFF)) begin
      r_overrunCnt <= r_overrunCnt + 16'd1;
    end
  end

  assign overrun_cnt_o = r_overrunCnt;
`endif

  assign bus.pcm_valid_o = r_pcmValid;
  assign bus.pcm_o       = r_pcm;
  assign bus.overrun_o   = r_overrun;
endmodule

// File: tb/tb_pdm_pcm_decimator.sv
// Directed bench for pdm_pcm_decimator (AVG_LOG2=2, DECIM=4, PCM_WIDTH=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pdm_pcm_decimator;
  logic clock_i;
  logic reset_n_i;
  int   assertCount;
  int   failCount;

  pdm_pcm_decimator_if #(.PCM_WIDTH(16)) bus ();

`ifdef PDM_DECIM_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt_o;
`endif

  pdm_pcm_decimator #(
    .AVG_LOG2(2),
    .DECIM(4),
    .PCM_WIDTH(16)
  ) dut (
    .clock_i(clock_i),
    .reset_n_i(reset_n_i),
    .bus(bus)
`ifdef PDM_DECIM_OVERRUN_CNT_EN
    ,.overrun_cnt_o(overrun_cnt_o)
`endif
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One-cycle word strobe, sampled at the rising edge inside the call.
  task automatic applyStimulus(input logic [15:0] word);
    bus.word_valid_i = 1'b1;
    bus.word_i       = word;
    @(negedge clock_i);
    bus.word_valid_i = 1'b0;
  endtask

  task automatic applyReset();
    reset_n_i = 1'b0;
    @(negedge clock_i);
    reset_n_i = 1'b1;
  endtask

  // After the last word of a window: nothing after E1, the sample after E2.
  task automatic expectSample(input string tag, input logic [15:0] value);
    @(negedge clock_i);
    checkOutput({tag, " validE1"}, 32'(bus.pcm_valid_o), 32'd0);
    @(negedge clock_i);
    checkOutput({tag, " validE2"}, 32'(bus.pcm_valid_o), 32'd1);
    checkOutput({tag, " pcm"}, 32'(bus.pcm_o), 32'(value));
    checkOutput({tag, " overrun"}, 32'(bus.overrun_o), 32'd0);
  endtask

  initial begin
    assertCount      = 0;
    failCount        = 0;
    bus.word_valid_i = 1'b0;
    bus.word_i       = '0;
    bus.pcm_ready_i  = 1'b1;
    reset_n_i        = 1'b0;
    @(negedge clock_i);
    @(negedge clock_i);
    reset_n_i = 1'b1;

    checkOutput("reset valid", 32'(bus.pcm_valid_o), 32'd0);
    checkOutput("reset pcm", 32'(bus.pcm_o), 32'd0);
    checkOutput("reset overrun", 32'(bus.overrun_o), 32'd0);
`ifdef PDM_DECIM_OVERRUN_CNT_EN
    checkOutput("reset cnt", 32'(overrun_cnt_o), 32'd0);
`endif

    // Half-density words with idle gaps: centred to zero, nothing during warm-up.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(16'hAAAA);
      @(negedge clock_i);
      checkOutput("warmup idle", 32'(bus.pcm_valid_o), 32'd0);
    end
    applyStimulus(16'hAAAA);
    expectSample("aaaa", 16'h0000);
    @(negedge clock_i);
    checkOutput("aaaa consumed", 32'(bus.pcm_valid_o), 32'd0);

    for (int k = 0; k < 4; k++) applyStimulus(16'hFFFF);
    expectSample("ffff", 16'h7FFF);
    for (int k = 0; k < 4; k++) applyStimulus(16'h0000);
    expectSample("zero", 16'h8000);
    for (int k = 0; k < 4; k++) applyStimulus(16'h000F);
    expectSample("000f", 16'hC000);
    @(negedge clock_i);
    checkOutput("000f consumed", 32'(bus.pcm_valid_o), 32'd0);

    // Back-pressure: second due sample is dropped while the first is held.
    applyReset();
    bus.pcm_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(16'hFFFF);
    expectSample("bp first", 16'h7FFF);
    for (int k = 0; k < 4; k++) applyStimulus(16'hFFFF);
    @(negedge clock_i);
    checkOutput("bp overrun E1", 32'(bus.overrun_o), 32'd0);
    @(negedge clock_i);
    checkOutput("bp overrun E2", 32'(bus.overrun_o), 32'd1);
    checkOutput("bp held pcm", 32'(bus.pcm_o), 32'h7FFF);
    checkOutput("bp held valid", 32'(bus.pcm_valid_o), 32'd1);
`ifdef PDM_DECIM_OVERRUN_CNT_EN
    @(negedge clock_i);
    checkOutput("bp cnt", 32'(overrun_cnt_o), 32'd1);
`else
    @(negedge clock_i);
`endif
    checkOutput("bp overrun pulse", 32'(bus.overrun_o), 32'd0);
    checkOutput("bp pcm stable", 32'(bus.pcm_o), 32'h7FFF);

    // Due sample lands on the same edge the consumer takes the held one.
    for (int k = 0; k < 4; k++) applyStimulus(16'h0000);
    @(negedge clock_i);
    checkOutput("same held", 32'(bus.pcm_o), 32'h7FFF);
    bus.pcm_ready_i = 1'b1;
    @(negedge clock_i);
    checkOutput("same valid", 32'(bus.pcm_valid_o), 32'd1);
    checkOutput("same pcm", 32'(bus.pcm_o), 32'h8000);
    checkOutput("same overrun", 32'(bus.overrun_o), 32'd0);
    @(negedge clock_i);
    checkOutput("same consumed", 32'(bus.pcm_valid_o), 32'd0);
`ifdef PDM_DECIM_OVERRUN_CNT_EN
    checkOutput("same cnt", 32'(overrun_cnt_o), 32'd1);
`endif

    // Reset mid warm-up restarts the window fill.
    for (int k = 0; k < 3; k++) applyStimulus(16'hFFFF);
    applyReset();
    checkOutput("midreset valid", 32'(bus.pcm_valid_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(16'h0000);
      @(negedge clock_i);
      @(negedge clock_i);
      checkOutput("rewarm idle", 32'(bus.pcm_valid_o), 32'd0);
    end
    applyStimulus(16'h0000);
    expectSample("rewarm", 16'h8000);
    repeat (3) @(negedge clock_i);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
